redmule_isolde_mem_arb: RTL
===========================

// Module: redmule_isolde_mem_arb
// PURPOSE
//  Arbitrates the cv32e40x instruction port and data port onto one shared 32-bit OBI-style
//  memory port. Sits between the core and the single-ported system memory of the ISOLDE
//  RedMulE subsystem. Round-robin on ties; once a request is presented, the selection is
//  locked until it is granted. In-order response routing uses an owner-ID FIFO.
// PARAMETERS
//  AddrWidth       32  address width, all ports
//  DataWidth       32  data width, all ports; BE width = DataWidth/8
//  MaxOutstanding  2   max granted-but-unanswered transactions (>=1)
// PORTS
//  clk_i          in   1     clock
//  rst_ni         in   1     asynchronous reset, active low
//  inst_req_i     in   1     instruction fetch request (read only)
//  inst_addr_i    in   AW    fetch address
//  inst_gnt_o     out  1     fetch request accepted
//  inst_rvalid_o  out  1     fetch response valid
//  inst_rdata_o   out  DW    fetch response data
//  data_req_i     in   1     data request
//  data_we_i      in   1     1 = write
//  data_be_i      in   DW/8  byte enables
//  data_addr_i    in   AW    data address
//  data_wdata_i   in   DW    write data
//  data_gnt_o     out  1     data request accepted
//  data_rvalid_o  out  1     data response valid (reads and writes)
//  data_rdata_o   out  DW    data response data
//  mem_req_o      out  1     memory request
//  mem_we_o       out  1     memory write enable
//  mem_be_o       out  DW/8  memory byte enables
//  mem_addr_o     out  AW    memory address
//  mem_wdata_o    out  DW    memory write data
//  mem_gnt_i      in   1     memory grant
//  mem_rvalid_i   in   1     memory response valid; at least 1 cycle after its grant
//  mem_rdata_i    in   DW    memory response data
//  outstanding_o  out  $clog2(MaxOutstanding+1)  current outstanding count
//  resp_err_o     out  1     1-cycle pulse: mem_rvalid_i arrived with no outstanding transaction
// BEHAVIOUR
//  - Reset values: all outputs 0. Internal state: FIFO empty, lock cleared, rr_last = INST.
//  - Selection (comb):
//    - If lock is set, sel = lock_id.
//    - Else, if only one requester is active, sel = that requester.
//    - Else, on a tie, sel = the requester that is not rr_last.
//  - mem_req_o = (inst_req_i | data_req_i) & (count < MaxOutstanding).
//    - No push/pop bypass: when full, the request is masked even if mem_rvalid_i is high that cycle.
//  - mem_* payload muxed from sel. For INST: mem_we_o = 0, mem_be_o = all ones, mem_wdata_o = 0.
//  - Grant: <sel>_gnt_o = mem_req_o & mem_gnt_i (comb). The non-selected gnt is 0.
//  - Lock:
//    - Set to sel when mem_req_o & !mem_gnt_i.
//    - Cleared on the handshake. Guarantees the OBI rule that a presented request is never withdrawn or switched.
//  - Handshake (mem_req_o & mem_gnt_i):
//    - Push sel into the owner FIFO.
//    - rr_last <= sel; lock cleared.
//  - Response:
//    - On mem_rvalid_i, pop the FIFO head.
//    - Pulse <head>_rvalid_o for one cycle, same cycle (comb).
//    - <head>_rdata_o = mem_rdata_i. The other rdata_o is held 0.
//  - Ordering: responses return in grant order. A push and a pop in the same cycle keep count unchanged.
//  - Empty pop: mem_rvalid_i with count == 0 gives resp_err_o = 1 for one cycle. The response is dropped, both rvalid_o stay 0, and count stays 0.
//  - Requester drops req while locked and ungranted: a protocol violation. The arbiter keeps the lock and keeps mem_req_o high with the held payload until granted. Only the grant outcome is checked.
//  - Reset mid-operation: FIFO, lock and rr_last reinitialise asynchronously. In-flight responses arriving after reset raise resp_err_o.
//  - outstanding_o = FIFO count, registered.
// TESTING
//  - T1 single fetch: inst_req with addr 0x1C00_0080, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF
//    -> inst_gnt_o pulse; inst_rvalid_o with 0xDEADBEEF; data_rvalid_o = 0.
//  - T2 tie after reset: both req, mem_gnt_i = 1 held
//    -> grants in order DATA, INST, DATA, INST.
//  - T3 lock: data_req and mem_gnt_i = 0 for 3 cycles, inst_req asserted in cycle 1
//    -> mem_addr_o stays on data_addr for all 3 cycles; inst_gnt_o = 0 until data is granted.
//  - T4 full (MaxOutstanding = 2): two grants with no rvalid
//    -> mem_req_o = 0 and outstanding_o = 2.
//    -> The first rvalid routes to the first owner; mem_req_o reasserts the next cycle.
//  - T5 interleaved order: grant INST, then DATA write with be = 4'b0011, then two rvalids
//    -> inst_rvalid_o, then data_rvalid_o, in that order.
//  - T6 spurious response: mem_rvalid_i with the FIFO empty
//    -> resp_err_o = 1 for 1 cycle; no rvalid_o.
//    -> Assert rst_ni low with 1 outstanding: outstanding_o = 0 immediately.

Source files
------------

// File: rtl/redmule_isolde_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : redmule_isolde_mem_arb                                        |
// | Purpose  : Round-robin arbiter of core fetch/data ports onto one OBI port|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module redmule_isolde_mem_arb #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 inst_req_i,
  input  logic [AddrWidth-1:0]                 inst_addr_i,
  output logic                                 inst_gnt_o,
  output logic                                 inst_rvalid_o,
  output logic [DataWidth-1:0]                 inst_rdata_o,
  input  logic                                 data_req_i,
  input  logic                                 data_we_i,
  input  logic [DataWidth/8-1:0]               data_be_i,
  input  logic [AddrWidth-1:0]                 data_addr_i,
  input  logic [DataWidth-1:0]                 data_wdata_i,
  output logic                                 data_gnt_o,
  output logic                                 data_rvalid_o,
  output logic [DataWidth-1:0]                 data_rdata_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [DataWidth/8-1:0]               mem_be_o,
  output logic [AddrWidth-1:0]                 mem_addr_o,
  output logic [DataWidth-1:0]                 mem_wdata_o,
  input  logic                                 mem_gnt_i,
  input  logic                                 mem_rvalid_i,
  input  logic [DataWidth-1:0]                 mem_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 resp_err_o
);

  localparam int unsigned BE_W  = DataWidth / 8;
  localparam int unsigned CNT_W = $clog2(MaxOutstanding + 1);
  localparam int unsigned PTR_W = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MaxOutstanding);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MaxOutstanding - 1);

  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

  owner_e                 w_sel, w_head;
  owner_e                 r_lock_id, r_rr_last;
  logic                   r_lock;
  owner_e                 r_owner [MaxOutstanding];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_hold_we;
  logic [BE_W-1:0]        r_hold_be;
  logic [AddrWidth-1:0]   r_hold_addr;
  logic [DataWidth-1:0]   r_hold_wdata;
  logic                   w_live_we;
  logic [BE_W-1:0]        w_live_be;
  logic [AddrWidth-1:0]   w_live_addr;
  logic [DataWidth-1:0]   w_live_wdata;
  logic                   w_hs, w_pop;

  always_comb begin
    w_sel = OWN_INST;
    if (r_lock)                         w_sel = r_lock_id;
    else if (data_req_i && !inst_req_i) w_sel = OWN_DATA;
    else if (data_req_i && inst_req_i)  w_sel = (r_rr_last == OWN_INST) ? OWN_DATA : OWN_INST;
  end

  always_comb begin
    w_live_we    = 1'b0;
    w_live_be    = '1;
    w_live_addr  = inst_addr_i;
    w_live_wdata = '0;
    if (w_sel == OWN_DATA) begin
      w_live_we    = data_we_i;
      w_live_be    = data_be_i;
      w_live_addr  = data_addr_i;
      w_live_wdata = data_wdata_i;
    end
  end

  // A locked request stays asserted even if the requester withdraws it.
  assign mem_req_o = (inst_req_i | data_req_i | r_lock) & (r_count < MAX_CNT);

  // Payload is driven only while requesting, so idle outputs read as zero.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_we_o    = r_lock ? r_hold_we    : w_live_we;
      mem_be_o    = r_lock ? r_hold_be    : w_live_be;
      mem_addr_o  = r_lock ? r_hold_addr  : w_live_addr;
      mem_wdata_o = r_lock ? r_hold_wdata : w_live_wdata;
    end
  end

  assign w_hs       = mem_req_o & mem_gnt_i;
  assign inst_gnt_o = w_hs & (w_sel == OWN_INST);
  assign data_gnt_o = w_hs & (w_sel == OWN_DATA);

  assign w_head        = r_owner[r_rd_ptr];
  assign w_pop         = mem_rvalid_i & (r_count != '0);
  assign resp_err_o    = mem_rvalid_i & (r_count == '0);
  assign inst_rvalid_o = w_pop & (w_head == OWN_INST);
  assign data_rvalid_o = w_pop & (w_head == OWN_DATA);
  assign inst_rdata_o  = inst_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o  = data_rvalid_o ? mem_rdata_i : '0;
  assign outstanding_o = r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock       <= 1'b0;
      r_lock_id    <= OWN_INST;
      r_rr_last    <= OWN_INST;
      r_hold_we    <= 1'b0;
      r_hold_be    <= '0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
    end else if (w_hs) begin
      r_lock    <= 1'b0;
      r_rr_last <= w_sel;
    end else if (mem_req_o && !r_lock) begin
      r_lock       <= 1'b1;
      r_lock_id    <= w_sel;
      r_hold_we    <= w_live_we;
      r_hold_be    <= w_live_be;
      r_hold_addr  <= w_live_addr;
      r_hold_wdata <= w_live_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_hs)  r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs) r_owner[r_wr_ptr] <= w_sel;
  end

endmodule
`default_nettype wire
